// File: rtl/lsu_align.sv
// lsu_align: byte-addressed load/store alignment onto a word RAM, splitting word-crossing accesses.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of splitting them.
module lsu_align #(
  parameter int RAM_SIZE_LOG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_mode,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [RAM_SIZE_LOG-1:0] mem_ra,
  input  logic [31:0]             mem_rd,
  output logic                    mem_we,
  output logic [RAM_SIZE_LOG-1:0] mem_wa,
  output logic [31:0]             mem_wd
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t                  state_q;
  logic                    we_q, cross_q, err_q;
  logic [2:0]              mode_q;
  logic [1:0]              off_q;
  logic [RAM_SIZE_LOG-1:0] w_q, ra_q, wa_q;
  logic [31:0]             wdata_q, buf0_q, wd_q, rdata_q;
  logic [RAM_SIZE_LOG-1:0] r_w;
  logic [2:0]              r_n;
  logic                    r_cross, r_mis, r_err;
  logic [3:0]              bm, lm;
  logic [7:0]              m8;
  logic [63:0]             sd, lsh;
  logic [31:0]             ld, merged, ld_res;
  assign r_w     = req_addr[RAM_SIZE_LOG+1:2];
  assign r_n     = req_mode[1] ? 3'd4 : req_mode[0] ? 3'd2 : 3'd1;
  assign r_cross = ({1'b0, req_addr[1:0]} + r_n) > 3'd4;
`ifdef LSU_MISALIGN_TRAP_EN
  assign r_mis   = |(req_addr[1:0] & (r_n[1:0] - 2'd1));
`else
  assign r_mis   = 1'b0;
`endif
  assign r_err   = (req_mode == 3'b011) || (req_mode[2:1] == 2'b11) || (req_we && req_mode[2]) ||
                   ((req_addr >> (RAM_SIZE_LOG + 2)) != 32'd0) || (r_cross && (&r_w)) || r_mis;
  // Lane mask and data spread across the 64-bit window {word w+1, word w}
  assign bm     = mode_q[1] ? 4'hf : mode_q[0] ? 4'h3 : 4'h1;
  assign m8     = {4'b0, bm} << off_q;
  assign sd     = {32'b0, wdata_q} << {off_q, 3'b0};
  assign lm     = (state_q == ACC1) ? m8[7:4] : m8[3:0];
  assign ld     = (state_q == ACC1) ? sd[63:32] : sd[31:0];
  assign lsh    = ((state_q == ACC1) ? {mem_rd, buf0_q} : {32'b0, mem_rd}) >> {off_q, 3'b0};
  assign ld_res = mode_q[1:0] == 2'b00 ? {{24{~mode_q[2] & lsh[7]}}, lsh[7:0]} :
                  mode_q[1:0] == 2'b01 ? {{16{~mode_q[2] & lsh[15]}}, lsh[15:0]} : lsh[31:0];
  always_comb begin
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = lm[i] ? ld[8*i +: 8] : mem_rd[8*i +: 8];
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_ra    = ra_q;
  assign mem_wa    = wa_q;
  assign mem_we    = we_q && (state_q == ACC0 || state_q == ACC1);
  assign mem_wd    = mem_we ? merged : wd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 3'b0;
      off_q   <= 2'b0;
      w_q     <= '0;
      ra_q    <= '0;
      wa_q    <= '0;
      wdata_q <= 32'b0;
      buf0_q  <= 32'b0;
      wd_q    <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we & ~r_err;
          mode_q  <= req_mode;
          off_q   <= req_addr[1:0];
          w_q     <= r_w;
          wdata_q <= req_wdata;
          cross_q <= r_cross;
          err_q   <= r_err;
          rdata_q <= 32'b0;
          state_q <= r_err ? RESP : ACC0;
          if (!r_err) ra_q <= r_w;
          if (!r_err && req_we) wa_q <= r_w;
        end
        ACC0: begin
          buf0_q <= mem_rd;
          if (mem_we) wd_q <= merged;
          if (cross_q) begin
            state_q <= ACC1;
            ra_q    <= w_q + 1'b1;
            if (we_q) wa_q <= w_q + 1'b1;
          end else begin
            state_q <= RESP;
            rdata_q <= we_q ? 32'b0 : ld_res;
          end
        end
        ACC1: begin
          if (mem_we) wd_q <= merged;
          rdata_q <= we_q ? 32'b0 : ld_res;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed checks of lsu_align against a negedge-write word RAM model.
module tb_lsu_align;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, req_ready, rsp_valid, rsp_err, mem_we;
  logic [2:0]  req_mode = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, mem_rd, mem_wd;
  logic [7:0]  mem_ra, mem_wa;
  logic [31:0] mem [256];
  int tests = 0, fails = 0;
  lsu_align #(.RAM_SIZE_LOG(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_wa(mem_wa), .mem_wd(mem_wd)
  );
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_ra];
  always @(negedge clk) if (mem_we) mem[mem_wa] <= mem_wd;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input string tag, input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_we);
    int lat, pulses;
    logic [31:0] rd;
    logic err;
    pulses = 0;
    rd = 'x;
    err = 'x;
    @(negedge clk);
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      if (mem_we) pulses++;
      if (rsp_valid) begin
        rd = rsp_rdata;
        err = rsp_err;
        break;
      end
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".we_pulses"}, pulses, exp_we);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", req_ready, 1);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rdata", rsp_rdata, 0);
    check("rst.err", rsp_err, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_ra", mem_ra, 0);
    check("rst.mem_wa", mem_wa, 0);
    check("rst.mem_wd", mem_wd, 0);
    @(negedge clk) rst_n = 1;
    access("sw", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1);
    check("sw.wa", mem_wa, 4);
    check("sw.wd", mem_wd, 32'hDEADBEEF);
    check("sw.mem4", mem[4], 32'hDEADBEEF);
    access("lw", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 2, 0);
    mem[4] = 32'h11223344;
    access("sb", 1, 3'b000, 32'h13, 32'h000000AA, 0, 0, 2, 1);
    check("sb.mem4", mem[4], 32'hAA223344);
    access("lb", 0, 3'b000, 32'h13, 0, 32'hFFFFFFAA, 0, 2, 0);
    access("lbu", 0, 3'b100, 32'h13, 0, 32'h000000AA, 0, 2, 0);
    access("lh", 0, 3'b001, 32'h12, 0, 32'hFFFFAA22, 0, 2, 0);
    access("lhu", 0, 3'b101, 32'h12, 0, 32'h0000AA22, 0, 2, 0);
    mem[3] = 32'hDDCCBBAA;
    mem[4] = 32'h44332211;
`ifdef LSU_MISALIGN_TRAP_EN
    access("lw_cross", 0, 3'b010, 32'h0E, 0, 0, 1, 1, 0);
    access("sh_cross", 1, 3'b001, 32'h0F, 32'h5566, 0, 1, 1, 0);
    check("sh_cross.mem3", mem[3], 32'hDDCCBBAA);
    check("sh_cross.mem4", mem[4], 32'h44332211);
`else
    access("lw_cross", 0, 3'b010, 32'h0E, 0, 32'h2211DDCC, 0, 3, 0);
    access("sh_cross", 1, 3'b001, 32'h0F, 32'h5566, 0, 0, 3, 2);
    check("sh_cross.mem3", mem[3], 32'h66CCBBAA);
    check("sh_cross.mem4", mem[4], 32'h44332255);
`endif
    access("lw_oob", 0, 3'b010, 32'h400, 0, 0, 1, 1, 0);
    access("lh_wrap", 0, 3'b001, 32'h3FF, 0, 0, 1, 1, 0);
    access("sbu", 1, 3'b100, 32'h20, 32'h12, 0, 1, 1, 0);
    access("mode7", 0, 3'b111, 32'h0, 0, 0, 1, 1, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    mem[3] = 32'hDDCCBBAA;
    mem[4] = 32'h44332211;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_mode = 3'b001; req_addr = 32'h0F; req_wdata = 32'h5566;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("mid_rst.rsp_valid", rsp_valid, 0);
    check("mid_rst.mem_we", mem_we, 0);
    check("mid_rst.mem_ra", mem_ra, 0);
    check("mid_rst.mem_wa", mem_wa, 0);
    check("mid_rst.mem_wd", mem_wd, 0);
    check("mid_rst.ready", req_ready, 1);
    repeat (2) @(negedge clk);
    check("mid_rst.mem3", mem[3], 32'h66CCBBAA);
    check("mid_rst.mem4", mem[4], 32'h44332211);
    rst_n = 1;
    access("post_rst_lw", 0, 3'b010, 32'h0E, 0, 32'h221166CC, 0, 3, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
